// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge data table.
// Contents:
//   DATA_TABLE_ADDR_W  - word address width of the data table (1024 words)
//   DATA_TABLE_DATA_W  - word width of the data table
//   BRIDGE_SYNC_STAGES - depth of the endian-flag synchronizer
//   byte_swap32()      - reverses the byte order of a 32-bit word
package bridge_pkg;

    localparam int DATA_TABLE_ADDR_W  = 10;
    localparam int DATA_TABLE_DATA_W  = 32;
    localparam int BRIDGE_SYNC_STAGES = 3;

    function automatic logic [31:0] byte_swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/bridge_datatable_ram_if.sv
// Port bundle for the bridge data table.
// Port A (core side):   address_a, data_a, wren_a -> q_a (native byte order)
// Port B (bridge side): address_b, data_b, wren_b -> q_b (bridge byte order)
// master: the client driving both ports; slave: the data table itself.
interface bridge_datatable_ram_if
    import bridge_pkg::*;
#(
    parameter int ADDR_W = DATA_TABLE_ADDR_W,
    parameter int DATA_W = DATA_TABLE_DATA_W
);

    logic [ADDR_W-1:0] address_a;
    logic [DATA_W-1:0] data_a;
    logic              wren_a;
    logic [DATA_W-1:0] q_a;

    logic [ADDR_W-1:0] address_b;
    logic [DATA_W-1:0] data_b;
    logic              wren_b;
    logic [DATA_W-1:0] q_b;

    modport master (
        output address_a, data_a, wren_a,
        output address_b, data_b, wren_b,
        input  q_a, q_b
    );

    modport slave (
        input  address_a, data_a, wren_a,
        input  address_b, data_b, wren_b,
        output q_a, q_b
    );

endinterface

// File: rtl/sync_nstage.sv
// N-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk     - destination clock
//   reset_n - asynchronous active-low reset, all stages cleared to 0
//   d       - asynchronous input
//   q       - synchronized output (last stage)
// STAGES must be at least 2. A change on d is visible on q after exactly
// STAGES rising edges.
module sync_nstage #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/bridge_datatable_ram.sv
// Dual-port data table shared between the core (port A) and the bridge
// (port B, 0xF8xx2xxx window). Port B is endian-aware: when the synchronized
// bridge_endian_little flag is 1, port B write and read data are byte-swapped.
// Ports:
//   clk                  - single clock for both ports and the synchronizer
//   reset_n              - asynchronous active-low reset (outputs and flag only)
//   bridge_endian_little - asynchronous endian flag, 1 = little-endian bridge
//   endian_little_s      - synchronized endian flag
//   bus                  - port A / port B address, data, write enable, read data
module bridge_datatable_ram
    import bridge_pkg::*;
#(
    parameter int ADDR_W      = DATA_TABLE_ADDR_W,
    parameter int DATA_W      = DATA_TABLE_DATA_W,
    parameter int SYNC_STAGES = BRIDGE_SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    bridge_endian_little,
    output logic                    endian_little_s,
    bridge_datatable_ram_if.slave   bus
);

    localparam int BYTES = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic              endian_sync;
    logic [DATA_W-1:0] data_b_swapped;
    logic [DATA_W-1:0] wdata_b;
    logic              wren_b_eff;
    logic [DATA_W-1:0] q_a_reg;
    logic [DATA_W-1:0] q_b_reg;
    logic [DATA_W-1:0] q_b_swapped;

    // Power-up contents are zero by the device's configuration; the array is
    // never reset so it can map onto block RAM.
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    sync_nstage #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bridge_endian_little),
        .q       (endian_sync)
    );

    assign endian_little_s = endian_sync;

    // Byte-order reversal for both directions of port B.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_swap
        assign data_b_swapped[gi*8 +: 8] = bus.data_b[(BYTES-1-gi)*8 +: 8];
        assign q_b_swapped[gi*8 +: 8]    = q_b_reg[(BYTES-1-gi)*8 +: 8];
    end

    // The table stores words in native (core) order.
    assign wdata_b = endian_sync ? data_b_swapped : bus.data_b;

    // Collision priority: port A wins, port B's write to the same word is dropped.
    assign wren_b_eff = bus.wren_b && !(bus.wren_a && (bus.address_a == bus.address_b));

    always_ff @(posedge clk) begin
        if (bus.wren_a) begin
            mem[bus.address_a] <= bus.data_a;
        end
        if (wren_b_eff) begin
            mem[bus.address_b] <= wdata_b;
        end
    end

    // Registered reads. A port writing a word reads it back through its own
    // bypass; the other port sees the array, i.e. the old word this cycle.
    // A dropped port B write does not bypass, so port B sees the old word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_a_reg <= '0;
            q_b_reg <= '0;
        end else begin
            q_a_reg <= bus.wren_a ? bus.data_a : mem[bus.address_a];
            q_b_reg <= wren_b_eff ? wdata_b    : mem[bus.address_b];
        end
    end

    assign bus.q_a = q_a_reg;
    // Output swap follows the current flag, not the flag at read time.
    assign bus.q_b = endian_sync ? q_b_swapped : q_b_reg;

endmodule

// File: tb/tb_bridge_datatable_ram.sv
module tb_bridge_datatable_ram;
    import bridge_pkg::*;

    typedef struct {
        int          sel;   // 0 = q_a, 1 = q_b, 2 = endian_little_s
        string       tag;
        logic [31:0] exp;
        int          due;
    } sb_entry_t;

    logic clk = 1'b0;
    logic reset_n;
    logic bridge_endian_little;
    logic endian_little_s;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    sb_entry_t sb[$];

    bridge_datatable_ram_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    bridge_datatable_ram dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .bridge_endian_little (bridge_endian_little),
        .endian_little_s      (endian_little_s),
        .bus                  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic expect_at(input int sel, input string tag, input logic [31:0] v, input int lat);
        sb_entry_t e;
        e.sel = sel;
        e.tag = tag;
        e.exp = v;
        e.due = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [9:0] aa, input logic [31:0] da, input logic wa,
                         input logic [9:0] ab, input logic [31:0] db, input logic wb);
        @(negedge clk);
        #1;
        bus.address_a = aa;
        bus.data_a    = da;
        bus.wren_a    = wa;
        bus.address_b = ab;
        bus.data_b    = db;
        bus.wren_b    = wb;
    endtask

    task automatic idle(input int n, input logic [9:0] ab);
        for (int i = 0; i < n; i++) drive(10'd0, 32'd0, 1'b0, ab, 32'd0, 1'b0);
    endtask

    // Monitor: compare every scoreboard entry whose due cycle has arrived.
    always @(negedge clk) begin : monitor
        logic [31:0] obs;
        int k;
        k = 0;
        while (k < sb.size()) begin
            if (sb[k].due <= cyc) begin
                case (sb[k].sel)
                    0:       obs = bus.q_a;
                    1:       obs = bus.q_b;
                    default: obs = {31'd0, endian_little_s};
                endcase
                check_val(sb[k].tag, obs, sb[k].exp);
                sb.delete(k);
            end else begin
                k++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n              = 1'b0;
        bridge_endian_little = 1'b1;
        bus.address_a = '0; bus.data_a = '0; bus.wren_a = 1'b0;
        bus.address_b = '0; bus.data_b = '0; bus.wren_b = 1'b0;

        // Reset held with the flag input at 1
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_q_a", bus.q_a, 32'd0);
        check_val("rst_q_b", bus.q_b, 32'd0);
        check_val("rst_endian", {31'd0, endian_little_s}, 32'd0);

        // Release: flag appears exactly on the 3rd edge
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        expect_at(2, "sync_e1", 32'd0, 1);
        expect_at(2, "sync_e2", 32'd0, 2);
        expect_at(2, "sync_e3", 32'd1, 3);
        idle(3, 10'd0);

        // Little-endian B write, read back on both ports
        drive(10'd0, 32'd0, 1'b0, 10'd2, 32'h11223344, 1'b1);
        expect_at(1, "le_b_wt", 32'h11223344, 1);
        drive(10'd2, 32'd0, 1'b0, 10'd2, 32'd0, 1'b0);
        expect_at(0, "le_a_rd", byte_swap32(32'h11223344), 1);
        expect_at(1, "le_b_rd", 32'h11223344, 1);

        // Flag back to big-endian
        drive(10'd0, 32'd0, 1'b0, 10'd0, 32'd0, 1'b0);
        bridge_endian_little = 1'b0;
        expect_at(2, "sync_f1", 32'd1, 1);
        expect_at(2, "sync_f2", 32'd1, 2);
        expect_at(2, "sync_f3", 32'd0, 3);
        idle(3, 10'd0);

        // Port A loop
        drive(10'd5, 32'h12345678, 1'b1, 10'd0, 32'd0, 1'b0);
        expect_at(0, "a_wt", 32'h12345678, 1);
        drive(10'd5, 32'd0, 1'b0, 10'd0, 32'd0, 1'b0);
        expect_at(0, "a_rd", 32'h12345678, 1);

        // Big-endian B write at the top address
        drive(10'd0, 32'd0, 1'b0, 10'h3FF, 32'hAABBCCDD, 1'b1);
        expect_at(1, "be_b_wt", 32'hAABBCCDD, 1);
        drive(10'h3FF, 32'd0, 1'b0, 10'h3FF, 32'd0, 1'b0);
        expect_at(0, "be_a_rd", 32'hAABBCCDD, 1);
        expect_at(1, "be_b_rd", 32'hAABBCCDD, 1);

        // Collision at addr 7: A wins, B sees the previous word that edge
        drive(10'd7, 32'h55, 1'b1, 10'd0, 32'd0, 1'b0);
        drive(10'd7, 32'h1, 1'b1, 10'd7, 32'h2, 1'b1);
        expect_at(0, "col_a_wt", 32'h1, 1);
        expect_at(1, "col_b_old", 32'h55, 1);
        drive(10'd7, 32'd0, 1'b0, 10'd7, 32'd0, 1'b0);
        expect_at(0, "col_a_rd", 32'h1, 1);
        expect_at(1, "col_b_rd", 32'h1, 1);

        // Cross-port read during B write: A gets old word, new word next cycle
        drive(10'd20, 32'h1111, 1'b1, 10'd0, 32'd0, 1'b0);
        drive(10'd20, 32'd0, 1'b0, 10'd20, 32'h2222, 1'b1);
        expect_at(0, "xrdw_old", 32'h1111, 1);
        drive(10'd20, 32'd0, 1'b0, 10'd20, 32'd0, 1'b0);
        expect_at(0, "xrdw_new", 32'h2222, 1);
        expect_at(1, "xrdw_b", 32'h2222, 1);

        // Simultaneous writes to different addresses both land
        drive(10'd10, 32'hA0A0, 1'b1, 10'd11, 32'hB0B0, 1'b1);
        drive(10'd11, 32'd0, 1'b0, 10'd10, 32'd0, 1'b0);
        expect_at(0, "dual_a_rd", 32'hB0B0, 1);
        expect_at(1, "dual_b_rd", 32'hA0A0, 1);

        // Flag toggle while B reads addr 9
        drive(10'd9, 32'hDEADBEEF, 1'b1, 10'd9, 32'd0, 1'b0);
        drive(10'd0, 32'd0, 1'b0, 10'd9, 32'd0, 1'b0);
        bridge_endian_little = 1'b1;
        expect_at(1, "tog_e1", 32'hDEADBEEF, 1);
        expect_at(1, "tog_e2", 32'hDEADBEEF, 2);
        expect_at(1, "tog_e3", byte_swap32(32'hDEADBEEF), 3);
        idle(3, 10'd9);

        // Reset mid-operation: outputs clear at once, memory survives
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_q_a", bus.q_a, 32'd0);
        check_val("mid_rst_q_b", bus.q_b, 32'd0);
        check_val("mid_rst_endian", {31'd0, endian_little_s}, 32'd0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        drive(10'd5, 32'd0, 1'b0, 10'h3FF, 32'd0, 1'b0);
        expect_at(0, "keep_a", 32'h12345678, 1);
        expect_at(1, "keep_b", 32'hAABBCCDD, 1);
        expect_at(2, "keep_endian", 32'd1, 2);
        idle(3, 10'd0);

        // Every scoreboard entry must have been consumed
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        check_val("sb_drain", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
